// File: rtl/watch_alarm_ctrl.sv
// Alarm controller beside the watch counter: set/arm via buttons,
// match against live time, ring with auto-stop and snooze.
module watch_alarm_ctrl #(
    parameter int RING_TICKS = 12,
    parameter int SNOOZE_MIN = 5
) (
    input  logic       Clk_5sec,
    input  logic       reset,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [4:0] hours,
    input  logic       mode_btn,
    input  logic       inc_btn,
    input  logic       stop_btn,
    input  logic       snooze_btn,
    output logic [4:0] alarm_hours,
    output logic [5:0] alarm_minutes,
    output logic       alarm_armed,
    output logic       ringing,
    output logic [2:0] state
);

    localparam int CW = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SET_HR  = 3'd1,
        SET_MIN = 3'd2,
        RINGING = 3'd3,
        SNOOZE  = 3'd4
    } state_t;

    state_t      state_q;
    logic [4:0]  alarm_hr_q;
    logic [5:0]  alarm_min_q;
    logic        armed_q;
    logic        ringing_q;
    logic [CW-1:0] ring_cnt_q;
    logic [4:0]  snz_hr_q;
    logic [5:0]  snz_min_q;
    logic        mode_prev_q;
    logic        inc_prev_q;
    logic        stop_prev_q;
    logic        snz_prev_q;

    logic        mode_p;
    logic        inc_p;
    logic        stop_p;
    logic        snz_p;
    logic        alarm_hit;
    logic        snz_hit;
    logic        ring_last;
    logic [6:0]  snz_sum;
    logic        snz_wrap;
    logic [5:0]  snz_min_d;
    logic [4:0]  snz_hr_d;
    logic [4:0]  alarm_hr_d;
    logic [5:0]  alarm_min_d;

    // Rising-edge presses and time comparisons for this edge
    always_comb begin
        mode_p    = mode_btn & ~mode_prev_q;
        inc_p     = inc_btn & ~inc_prev_q;
        stop_p    = stop_btn & ~stop_prev_q;
        snz_p     = snooze_btn & ~snz_prev_q;
        alarm_hit = (hours == alarm_hr_q) && (minutes == alarm_min_q)
                    && (seconds == 6'd0);
        snz_hit   = (hours == snz_hr_q) && (minutes == snz_min_q)
                    && (seconds == 6'd0);
        ring_last = (ring_cnt_q == CW'(RING_TICKS - 1));
    end

    // Wrapped increments for the alarm fields and the snooze target
    always_comb begin
        alarm_hr_d  = (alarm_hr_q == 5'd23) ? 5'd0 : alarm_hr_q + 5'd1;
        alarm_min_d = (alarm_min_q == 6'd59) ? 6'd0 : alarm_min_q + 6'd1;
        snz_sum     = {1'b0, minutes} + 7'(SNOOZE_MIN);
        snz_wrap    = (snz_sum >= 7'd60);
        snz_min_d   = snz_wrap ? 6'(snz_sum - 7'd60) : snz_sum[5:0];
        snz_hr_d    = hours;
        if (snz_wrap) begin
            snz_hr_d = (hours == 5'd23) ? 5'd0 : hours + 5'd1;
        end
    end

    // Alarm FSM with registered outputs
    always_ff @(posedge Clk_5sec or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            alarm_hr_q  <= '0;
            alarm_min_q <= '0;
            armed_q     <= 1'b0;
            ringing_q   <= 1'b0;
            ring_cnt_q  <= '0;
            snz_hr_q    <= '0;
            snz_min_q   <= '0;
            mode_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            stop_prev_q <= 1'b0;
            snz_prev_q  <= 1'b0;
        end else begin
            mode_prev_q <= mode_btn;
            inc_prev_q  <= inc_btn;
            stop_prev_q <= stop_btn;
            snz_prev_q  <= snooze_btn;
            unique case (state_q)
                IDLE: begin
                    if (armed_q && alarm_hit) begin
                        state_q    <= RINGING;
                        ringing_q  <= 1'b1;
                        ring_cnt_q <= '0;
                    end else if (mode_p) begin
                        state_q <= SET_HR;
                    end else if (inc_p) begin
                        armed_q <= ~armed_q;
                    end
                end
                SET_HR: begin
                    if (mode_p) begin
                        state_q <= SET_MIN;
                    end else if (inc_p) begin
                        alarm_hr_q <= alarm_hr_d;
                    end
                end
                SET_MIN: begin
                    if (mode_p) begin
                        state_q <= IDLE;
                    end else if (inc_p) begin
                        alarm_min_q <= alarm_min_d;
                    end
                end
                RINGING: begin
                    ring_cnt_q <= ring_cnt_q + CW'(1);
                    if (stop_p) begin
                        state_q   <= IDLE;
                        ringing_q <= 1'b0;
                    end else if (snz_p) begin
                        state_q   <= SNOOZE;
                        ringing_q <= 1'b0;
                        snz_hr_q  <= snz_hr_d;
                        snz_min_q <= snz_min_d;
                    end else if (ring_last) begin
                        state_q   <= IDLE;
                        ringing_q <= 1'b0;
                    end
                end
                SNOOZE: begin
                    if (snz_hit) begin
                        state_q    <= RINGING;
                        ringing_q  <= 1'b1;
                        ring_cnt_q <= '0;
                    end else if (stop_p) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ringing_q <= 1'b0;
                end
            endcase
        end
    end

    assign alarm_hours   = alarm_hr_q;
    assign alarm_minutes = alarm_min_q;
    assign alarm_armed   = armed_q;
    assign ringing       = ringing_q;
    assign state         = state_q;

endmodule
